// File: rtl/dma_pkg.sv
// Types and constants shared by the DMA port adapters that sit in front of the DDR controller.
package dma_pkg;
    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int HALF_W = 16;

    localparam logic [2:0] MIG_CMD_READ = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WAIT,
        ST_LO,
        ST_HI,
        ST_DONE
    } rd_state_t;
endpackage

// File: rtl/dma_rd_port.sv
// Read-side DMA port: issues one burst read to the DDR controller, then streams each
// 32-bit FIFO word to the engine as two fp16 halves, low half first.
module dma_rd_port
    import dma_pkg::*;
#(
    parameter int BURST_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reads_en,
    input  logic [ADDR_W-1:0] addr,
    output logic [HALF_W-1:0] ob_data,
    output logic              ob_we,
    output logic              busy,
    output logic              burst_done,
    output logic              err,
    output logic              cmd_en,
    output logic [2:0]        cmd_instr,
    output logic [5:0]        cmd_bl,
    output logic [ADDR_W-1:0] cmd_byte_addr,
    input  logic              cmd_full,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_empty,
    input  logic              rd_error,
    input  logic              rd_overflow
);
    localparam logic [6:0] LAST_WORD = 7'(BURST_LEN);

    rd_state_t         state_q, state_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [ADDR_W-1:0] addr_d;
    logic [HALF_W-1:0] ob_data_d;
    logic              cmd_en_d, rd_en_d, ob_we_d, busy_d, burst_done_d;

    assign cmd_instr = MIG_CMD_READ;
    assign cmd_bl    = 6'(BURST_LEN - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            hold_q        <= '0;
            cmd_byte_addr <= '0;
            cmd_en        <= 1'b0;
            rd_en         <= 1'b0;
            ob_we         <= 1'b0;
            ob_data       <= '0;
            busy          <= 1'b0;
            burst_done    <= 1'b0;
            err           <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hold_q        <= hold_d;
            cmd_byte_addr <= addr_d;
            cmd_en        <= cmd_en_d;
            rd_en         <= rd_en_d;
            ob_we         <= ob_we_d;
            ob_data       <= ob_data_d;
            busy          <= busy_d;
            burst_done    <= burst_done_d;
            err           <= err | rd_error | rd_overflow;
        end
    end

    // Outputs are computed one edge ahead so every port leaves a flop.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        addr_d       = cmd_byte_addr;
        ob_data_d    = ob_data;
        busy_d       = busy;
        cmd_en_d     = 1'b0;
        rd_en_d      = 1'b0;
        ob_we_d      = 1'b0;
        burst_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (reads_en) begin
                    state_d  = ST_CMD;
                    addr_d   = addr & ~30'h3;
                    cmd_en_d = !cmd_full;
                    busy_d   = 1'b1;
                end
            end
            // A strobe already on the wire is the accepted command; otherwise retry.
            ST_CMD: begin
                if (cmd_en) state_d = ST_WAIT;
                else        cmd_en_d = !cmd_full;
            end
            ST_WAIT: begin
                if (!rd_empty) begin
                    state_d = ST_LO;
                    rd_en_d = 1'b1;
                    hold_d  = rd_data;
                end
            end
            ST_LO: begin
                ob_we_d   = 1'b1;
                ob_data_d = hold_q[15:0];
                state_d   = ST_HI;
            end
            ST_HI: begin
                ob_we_d   = 1'b1;
                ob_data_d = hold_q[31:16];
                cnt_d     = cnt_q + 7'd1;
                state_d   = (cnt_d == LAST_WORD) ? ST_DONE : ST_WAIT;
            end
            // First edge raises burst_done; second edge drops it and returns to IDLE.
            ST_DONE: begin
                if (!burst_done) begin
                    burst_done_d = 1'b1;
                    busy_d       = 1'b0;
                    cnt_d        = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_dma_rd_port.sv
// Directed bench for dma_rd_port with BURST_LEN=4 and a first-word-fall-through FIFO model.
module tb_dma_rd_port;
  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reads_en = 1'b0;
  logic [29:0] addr = '0;
  logic        cmd_full = 1'b0;
  logic [31:0] rd_data = '0;
  logic        rd_empty = 1'b1;
  logic        rd_error = 1'b0;
  logic        rd_overflow = 1'b0;
  logic [15:0] ob_data;
  logic        ob_we, busy, burst_done, err, cmd_en, rd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;

  dma_rd_port #(.BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .reads_en(reads_en), .addr(addr),
    .ob_data(ob_data), .ob_we(ob_we), .busy(busy), .burst_done(burst_done), .err(err),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
    .cmd_full(cmd_full), .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
    .rd_error(rd_error), .rd_overflow(rd_overflow)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // controller read FIFO model: pops on rd_en, flushed while rst is low
  logic [31:0] fifo_q[$];
  int rd_ptr = 0;
  always @(posedge clk) begin
    if (!rst) rd_ptr = fifo_q.size();
    else if (rd_en && rd_ptr < fifo_q.size()) rd_ptr = rd_ptr + 1;
    #1;
    rd_empty = (rd_ptr >= fifo_q.size());
    rd_data  = (rd_ptr < fifo_q.size()) ? fifo_q[rd_ptr] : 32'h0;
  end

  // output monitor, sampled on the falling edge
  logic [15:0] obs_q[$];
  int cmd_cyc_q[$];
  int done_cyc_q[$];
  int we_cyc_q[$];
  always @(negedge clk) begin
    if (ob_we) begin obs_q.push_back(ob_data); we_cyc_q.push_back(cyc); end
    if (cmd_en) cmd_cyc_q.push_back(cyc);
    if (burst_done) done_cyc_q.push_back(cyc);
  end

  // scoreboard
  logic [31:0] words [0:3] = '{32'h3413_3a07, 32'h378a_382f, 32'h3af5_2d2d, 32'h38db_2e19};
  logic [15:0] halves [0:7] = '{16'h3a07, 16'h3413, 16'h382f, 16'h378a,
                                16'h2d2d, 16'h3af5, 16'h2e19, 16'h38db};
  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks (all called on a falling edge)
  task automatic load_words(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(words[(first + i) % 4]);
      exp_q.push_back(halves[2 * ((first + i) % 4)]);
      exp_q.push_back(halves[2 * ((first + i) % 4) + 1]);
    end
  endtask

  task automatic request(input logic [29:0] a, output int req);
    addr = a;
    reads_en = 1'b1;
    req = cyc + 1;
    @(negedge clk);
    reads_en = 1'b0;
  endtask

  task automatic wait_size(input string tag, input int which, input int target);
    int got;
    got = 0;
    for (int i = 0; i < 300; i++) begin
      got = (which == 0) ? obs_q.size() : (which == 1) ? cmd_cyc_q.size() : done_cyc_q.size();
      if (got >= target) break;
      @(negedge clk);
    end
    check(tag, 32'(got >= target), 32'd1);
  endtask

  task automatic check_halves(input string tag, input int base, input int n);
    logic [15:0] obs;
    logic [15:0] exp;
    for (int i = 0; i < n; i++) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      obs = (base + i < obs_q.size()) ? obs_q[base + i] : 16'hxxxx;
      check($sformatf("%s_half%0d", tag, i), {16'h0, obs}, {16'h0, exp});
    end
  endtask

  int req, b_we, b_cmd, b_done;

  initial begin
    // reset state, checked while rst is held low
    #12;
    check("rst_cmd_en", {31'h0, cmd_en}, 32'd0);
    check("rst_cmd_instr", {29'h0, cmd_instr}, 32'd1);
    check("rst_cmd_bl", {26'h0, cmd_bl}, 32'd3);
    check("rst_cmd_addr", {2'b0, cmd_byte_addr}, 32'd0);
    check("rst_ob_we", {31'h0, ob_we}, 32'd0);
    check("rst_ob_data", {16'h0, ob_data}, 32'd0);
    check("rst_busy_done_err_rden", {28'h0, busy, burst_done, err, rd_en}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // single burst at 0x103
    b_we = obs_q.size(); b_cmd = cmd_cyc_q.size(); b_done = done_cyc_q.size();
    load_words(0, 4);
    @(negedge clk);
    request(30'h0000_0103, req);
    wait_size("t1_done_seen", 2, b_done + 1);
    check("t1_cmd_addr", {2'b0, cmd_byte_addr}, 32'h100);
    check("t1_cmd_bl", {26'h0, cmd_bl}, 32'd3);
    check("t1_cmd_lat", cmd_cyc_q[b_cmd] - req, 32'd0);
    check("t1_first_we_lat", we_cyc_q[b_we] - req, 32'd3);
    check("t1_done_lat", done_cyc_q[b_done] - req, 32'd14);
    check("t1_busy_at_done", {31'h0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    check("t1_cmd_count", cmd_cyc_q.size() - b_cmd, 32'd1);
    check("t1_we_count", obs_q.size() - b_we, 32'd8);
    check("t1_done_count", done_cyc_q.size() - b_done, 32'd1);
    check("t1_err", {31'h0, err}, 32'd0);
    check_halves("t1", b_we, 8);

    // command FIFO full for five edges after the request
    b_we = obs_q.size(); b_cmd = cmd_cyc_q.size(); b_done = done_cyc_q.size();
    load_words(0, 4);
    @(negedge clk);
    cmd_full = 1'b1;
    request(30'h0000_0040, req);
    repeat (4) @(negedge clk);
    check("t2_no_cmd_while_full", cmd_cyc_q.size() - b_cmd, 32'd0);
    cmd_full = 1'b0;
    wait_size("t2_done_seen", 2, b_done + 1);
    check("t2_cmd_lat", cmd_cyc_q[b_cmd] - req, 32'd5);
    repeat (4) @(negedge clk);
    check("t2_cmd_count", cmd_cyc_q.size() - b_cmd, 32'd1);
    check("t2_cmd_addr", {2'b0, cmd_byte_addr}, 32'h40);
    check_halves("t2", b_we, 8);

    // FIFO runs dry for three cycles between words 2 and 3
    b_we = obs_q.size(); b_done = done_cyc_q.size();
    load_words(0, 2);
    @(negedge clk);
    request(30'h0000_0200, req);
    wait_size("t3_four_halves", 0, b_we + 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t3_gap%0d_we", i), {31'h0, ob_we}, 32'd0);
      check($sformatf("t3_gap%0d_busy", i), {31'h0, busy}, 32'd1);
    end
    load_words(2, 2);
    wait_size("t3_done_seen", 2, b_done + 1);
    repeat (2) @(negedge clk);
    check("t3_we_count", obs_q.size() - b_we, 32'd8);
    check_halves("t3", b_we, 8);

    // one-cycle overflow flag sets the sticky error
    rd_overflow = 1'b1;
    @(negedge clk);
    rd_overflow = 1'b0;
    check("t5_err_set", {31'h0, err}, 32'd1);

    // reads_en dropped after the first strobe: burst completes, no re-issue
    b_we = obs_q.size(); b_cmd = cmd_cyc_q.size(); b_done = done_cyc_q.size();
    load_words(0, 4);
    @(negedge clk);
    addr = 30'h0000_0300;
    reads_en = 1'b1;
    wait_size("t4a_first_we", 0, b_we + 1);
    reads_en = 1'b0;
    wait_size("t4a_done_seen", 2, b_done + 1);
    repeat (6) @(negedge clk);
    check("t4a_cmd_count", cmd_cyc_q.size() - b_cmd, 32'd1);
    check("t4a_we_count", obs_q.size() - b_we, 32'd8);
    check_halves("t4a", b_we, 8);

    // reads_en held high: second command two cycles after burst_done, from the new addr
    b_we = obs_q.size(); b_cmd = cmd_cyc_q.size(); b_done = done_cyc_q.size();
    load_words(0, 4);
    load_words(0, 4);
    @(negedge clk);
    addr = 30'h0000_0400;
    reads_en = 1'b1;
    wait_size("t4b_first_cmd", 1, b_cmd + 1);
    addr = 30'h0000_0407;
    wait_size("t4b_second_cmd", 1, b_cmd + 2);
    reads_en = 1'b0;
    check("t4b_cmd_gap", cmd_cyc_q[b_cmd + 1] - done_cyc_q[b_done], 32'd2);
    check("t4b_cmd_addr2", {2'b0, cmd_byte_addr}, 32'h404);
    wait_size("t4b_done2_seen", 2, b_done + 2);
    repeat (6) @(negedge clk);
    check("t4b_cmd_count", cmd_cyc_q.size() - b_cmd, 32'd2);
    check_halves("t4b", b_we, 16);
    check("t5_err_sticky", {31'h0, err}, 32'd1);

    // asynchronous reset after three halves of a burst
    b_we = obs_q.size();
    load_words(0, 4);
    @(negedge clk);
    request(30'h0000_0500, req);
    wait_size("t6_three_halves", 0, b_we + 3);
    #2;
    rst = 1'b0;
    #1;
    check("t6_ob_we", {31'h0, ob_we}, 32'd0);
    check("t6_ob_data", {16'h0, ob_data}, 32'd0);
    check("t6_busy_err", {30'h0, busy, err}, 32'd0);
    check("t6_cmd_addr", {2'b0, cmd_byte_addr}, 32'd0);
    check("t6_cmd_en_rd_en_done", {29'h0, cmd_en, rd_en, burst_done}, 32'd0);
    check("t6_cmd_instr_bl", {23'h0, cmd_instr, cmd_bl}, {23'h0, 3'b001, 6'd3});
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    b_we = obs_q.size(); b_cmd = cmd_cyc_q.size(); b_done = done_cyc_q.size();
    load_words(0, 4);
    @(negedge clk);
    request(30'h0000_0603, req);
    wait_size("t6_done_seen", 2, b_done + 1);
    check("t6_restart_cmd_lat", cmd_cyc_q[b_cmd] - req, 32'd0);
    check("t6_restart_addr", {2'b0, cmd_byte_addr}, 32'h600);
    check("t6_restart_done_lat", done_cyc_q[b_done] - req, 32'd14);
    repeat (2) @(negedge clk);
    check("t6_restart_we_count", obs_q.size() - b_we, 32'd8);
    check_halves("t6", b_we, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
